dio_test_sequencer: RTL

Autonomous controller that drives the DIO loopback checker's settings and status streams. On a start pulse it runs each selected DIO mode in turn:
- send the settings word;
- wait for the checker's pipeline to settle;
- dwell while accumulating sticky mismatch bits;
- send MODE_OFF.

It sits between the command parser (start, config) and the DIO checker. It replaces manual settings writes with one fixed, repeatable sequence and produces a compact pass/fail summary.

---
 rtl/dio_test_sequencer_pkg.sv | 53 +++++
 rtl/dio_test_sequencer_if.sv | 24 ++
 rtl/dio_test_sequencer_timer.sv | 25 ++
 rtl/dio_test_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dio_test_sequencer_pkg.sv
// Shared definitions for the DIO loopback checker and its test sequencer:
// mode codes, settings/status field positions and sequencer states.
package dio_test_pkg;

  typedef enum logic [1:0] {
    MODE_OFF           = 2'd0,
    MODE_TOP_TO_BOTTOM = 2'd1,
    MODE_PORT_PAIRS    = 2'd2,
    MODE_EMISSIONS     = 2'd3
  } dio_mode_e;

  localparam int unsigned SET_DIV_LSB       = 0;
  localparam int unsigned SET_PHASE_LSB     = 8;
  localparam int unsigned SET_MODE_LSB      = 16;
  localparam int unsigned STAT_NOT_RUNNING  = 16;
  localparam int unsigned STAT_PHASE_GE_DIV = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CFG,
    ST_SETTLE,
    ST_DWELL,
    ST_SEND_OFF,
    ST_NEXT,
    ST_DONE
  } seq_state_e;

  function automatic logic [2:0] lowest_bit(input logic [2:0] m);
    return m & (~m + 3'd1);
  endfunction

  // Mask bit order matches mode code minus one.
  function automatic dio_mode_e mode_of(input logic [2:0] onehot);
    case (onehot)
      3'b001:  return MODE_TOP_TO_BOTTOM;
      3'b010:  return MODE_PORT_PAIRS;
      3'b100:  return MODE_EMISSIONS;
      default: return MODE_OFF;
    endcase
  endfunction

  function automatic logic [31:0] settings_word(input dio_mode_e mode,
                                                input logic [7:0] phase,
                                                input logic [7:0] div);
    logic [31:0] w;
    w = '0;
    w[SET_DIV_LSB +: 8]   = div;
    w[SET_PHASE_LSB +: 8] = phase;
    w[SET_MODE_LSB +: 2]  = mode;
    return w;
  endfunction

endpackage

// File: rtl/dio_test_sequencer_if.sv
// Settings and status streams between the test sequencer (master) and the
// DIO loopback checker (slave).
interface dio_test_sequencer_if;
  logic [31:0] dio_settings_tdata;
  logic        dio_settings_tvalid;
  logic        dio_settings_tready;
  logic [31:0] dio_counter_status_tdata;
  logic        dio_counter_status_tvalid;
  logic        dio_counter_status_tready;

  modport master (
    output dio_settings_tdata, dio_settings_tvalid,
    input  dio_settings_tready,
    input  dio_counter_status_tdata, dio_counter_status_tvalid,
    output dio_counter_status_tready
  );

  modport slave (
    input  dio_settings_tdata, dio_settings_tvalid,
    output dio_settings_tready,
    output dio_counter_status_tdata, dio_counter_status_tvalid,
    input  dio_counter_status_tready
  );
endinterface

// File: rtl/dio_test_sequencer_timer.sv
// Loadable down-counter; done_o is high during the final counted cycle.
module dio_seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == W'(1));
endmodule

// File: rtl/dio_test_sequencer.sv
// Runs each selected DIO mode through config/settle/dwell/off on the checker
// streams and collects a per-mode pass/fail summary.
module dio_test_sequencer
  import dio_test_pkg::*;
#(
  parameter int unsigned SETTLE_PERIODS = 4,
  parameter int unsigned DWELL_W        = 24
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic [2:0]          mode_mask,
  input  logic [7:0]          clock_div_max,
  input  logic [7:0]          update_output_phase,
  input  logic [DWELL_W-1:0]  dwell_cycles,
  dio_test_sequencer_if.master dio,
  output logic                busy,
  output logic                done,
  output logic [2:0]          pass_mask,
  output logic [15:0]         fail_pins,
  output logic                cfg_err,
  output logic                aborted
);
  // Wide enough for SETTLE_PERIODS * 256 without wrap.
  localparam int unsigned SETTLE_W = $clog2(SETTLE_PERIODS + 1) + 9;

  seq_state_e         state_q, state_d;
  logic [2:0]         rem_q, rem_d, cur_q, cur_d, pass_q, pass_d;
  logic [7:0]         div_q, div_d, phase_q, phase_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [15:0]        acc_q, acc_d, fail_pins_q, fail_pins_d;
  logic               cfg_err_q, cfg_err_d, aborted_q, aborted_d;
  logic               abort_req_q, abort_req_d;

  logic [2:0]          rem_next;
  dio_mode_e           cur_mode;
  logic                loopback;
  logic [15:0]         stat_pins;
  logic                stat_cfg_bad;
  logic                unused_status;
  logic [8:0]          div_plus1;
  logic [SETTLE_W-1:0] settle_val;
  logic [DWELL_W-1:0]  dwell_val;
  logic                settle_load, settle_done, dwell_load, dwell_done;
  logic [31:0]         set_tdata;
  logic                set_tvalid, stat_tready;

  assign cur_mode      = mode_of(cur_q);
  assign loopback      = (cur_mode != MODE_EMISSIONS);
  assign stat_pins     = dio.dio_counter_status_tvalid ? dio.dio_counter_status_tdata[15:0] : '0;
  assign stat_cfg_bad  = dio.dio_counter_status_tvalid &
                         (dio.dio_counter_status_tdata[STAT_NOT_RUNNING] |
                          dio.dio_counter_status_tdata[STAT_PHASE_GE_DIV]);
  assign unused_status = ^dio.dio_counter_status_tdata[31:18];
  assign div_plus1     = {1'b0, div_q} + 9'd1;
  assign settle_val    = SETTLE_W'(SETTLE_PERIODS) * SETTLE_W'(div_plus1);
  assign dwell_val     = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign rem_next      = rem_q & ~cur_q;

  dio_seq_timer #(.W(SETTLE_W)) u_settle_timer (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (settle_load),
    .value_i (settle_val),
    .en_i    (state_q == ST_SETTLE),
    .done_o  (settle_done)
  );

  dio_seq_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (dwell_load),
    .value_i (dwell_val),
    .en_i    (state_q == ST_DWELL),
    .done_o  (dwell_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      cur_q       <= '0;
      div_q       <= '0;
      phase_q     <= '0;
      dwell_q     <= '0;
      acc_q       <= '0;
      pass_q      <= '0;
      fail_pins_q <= '0;
      cfg_err_q   <= 1'b0;
      aborted_q   <= 1'b0;
      abort_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cur_q       <= cur_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      dwell_q     <= dwell_d;
      acc_q       <= acc_d;
      pass_q      <= pass_d;
      fail_pins_q <= fail_pins_d;
      cfg_err_q   <= cfg_err_d;
      aborted_q   <= aborted_d;
      abort_req_q <= abort_req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cur_d       = cur_q;
    div_d       = div_q;
    phase_d     = phase_q;
    dwell_d     = dwell_q;
    acc_d       = acc_q;
    pass_d      = pass_q;
    fail_pins_d = fail_pins_q;
    cfg_err_d   = cfg_err_q;
    aborted_d   = aborted_q;
    abort_req_d = abort_req_q;
    settle_load = 1'b0;
    dwell_load  = 1'b0;
    set_tvalid  = 1'b0;
    set_tdata   = '0;
    stat_tready = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (mode_mask != '0)) begin
          rem_d       = mode_mask;
          cur_d       = lowest_bit(mode_mask);
          div_d       = clock_div_max;
          phase_d     = update_output_phase;
          dwell_d     = dwell_cycles;
          pass_d      = '0;
          fail_pins_d = '0;
          cfg_err_d   = 1'b0;
          aborted_d   = 1'b0;
          abort_req_d = 1'b0;
          state_d     = ST_SEND_CFG;
        end
      end
      ST_SEND_CFG: begin
        set_tvalid = 1'b1;
        set_tdata  = settings_word(cur_mode, phase_q, div_q);
        if (abort) abort_req_d = 1'b1;
        // An abort cannot withdraw a word already offered; finish it first.
        if (dio.dio_settings_tready) begin
          if (abort || abort_req_q) begin
            state_d = ST_SEND_OFF;
          end else begin
            settle_load = 1'b1;
            state_d     = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        stat_tready = 1'b1;
        if (abort) begin
          abort_req_d = 1'b1;
          state_d     = ST_SEND_OFF;
        end else if (settle_done) begin
          dwell_load = 1'b1;
          acc_d      = '0;
          state_d    = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (abort) begin
          abort_req_d = 1'b1;
          state_d     = ST_SEND_OFF;
        end else begin
          acc_d = acc_q | stat_pins;
          if (dwell_done) begin
            state_d   = ST_SEND_OFF;
            cfg_err_d = cfg_err_q | stat_cfg_bad;
            if (loopback) fail_pins_d = fail_pins_q | acc_d;
            if (!(stat_cfg_bad || (loopback && (acc_d != '0)))) pass_d = pass_q | cur_q;
          end
        end
      end
      ST_SEND_OFF: begin
        set_tvalid = 1'b1;
        set_tdata  = settings_word(MODE_OFF, phase_q, div_q);
        if (abort) abort_req_d = 1'b1;
        if (dio.dio_settings_tready) begin
          if (abort || abort_req_q) begin
            aborted_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        rem_d = rem_next;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (rem_next == '0) begin
          state_d = ST_DONE;
        end else begin
          cur_d   = lowest_bit(rem_next);
          state_d = ST_SEND_CFG;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dio.dio_settings_tdata        = set_tdata;
  assign dio.dio_settings_tvalid       = set_tvalid;
  assign dio.dio_counter_status_tready = stat_tready;
  assign busy      = (state_q != ST_IDLE);
  assign pass_mask = pass_q;
  assign fail_pins = fail_pins_q;
  assign cfg_err   = cfg_err_q;
  assign aborted   = aborted_q;
endmodule
